// File: rtl/pre_if_stage_pkg.sv
// Shared definitions for the pre-IF fetch-address generator: reset PC, PC-queue
// entry layout and redirect-priority encoding.
package pre_if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic        discard;
    } pcq_entry_t;

    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_BR   = 2'd1,
        REDIR_EXC  = 2'd2
    } redir_t;

    // An exception always wins; a branch is dropped while an exception redirect is pending.
    function automatic redir_t f_redir_sel(input logic exc, input logic br, input redir_t pend);
        redir_t kind;
        kind = REDIR_NONE;
        if (exc)
            kind = REDIR_EXC;
        else if (br && (pend != REDIR_EXC))
            kind = REDIR_BR;
        return kind;
    endfunction

    function automatic logic f_cancels(input redir_t kind, input logic [31:0] pc,
                                       input logic [31:0] keep_pc);
        return (kind == REDIR_EXC) || ((kind == REDIR_BR) && (pc != keep_pc));
    endfunction

endpackage

// File: rtl/pre_if_stage_pc_queue.sv
// In-order queue of outstanding fetch PCs with a parallel discard-marking port
// (mark every entry, or every entry whose pc differs from a kept pc).
module pre_if_stage_pc_queue
    import pre_if_stage_pkg::*;
#(
    parameter  int QDEPTH = 2,
    localparam int CW     = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  pcq_entry_t    i_push_entry,
    input  logic          i_pop,
    input  logic          i_mark_all,
    input  logic          i_mark_except,
    input  logic [31:0]   i_keep_pc,
    output pcq_entry_t    o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    pcq_entry_t    r_mem [QDEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_pop_ok;
    logic w_push_ok;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PW'(QDEPTH - 1))
            nxt = '0;
        else
            nxt = ptr + 1'b1;
        return nxt;
    endfunction

    assign w_pop_ok  = i_pop && (r_count != '0);
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok)
                r_wptr <= f_inc(r_wptr);
            if (w_pop_ok)
                r_rptr <= f_inc(r_rptr);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Stale slots may be marked too; they are fully overwritten on their next push.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (i_mark_all || (i_mark_except && (r_mem[i].pc != i_keep_pc)))
                r_mem[i].discard <= 1'b1;
        end
        if (w_push_ok)
            r_mem[r_wptr] <= i_push_entry;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = (r_count == CW'(QDEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/pre_if_stage.sv
// Pre-IF stage: generates sequential fetch requests, applies cp0/branch redirects
// and pairs each returned instruction with its PC and discard flag.
module pre_if_stage
    import pre_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exception_like_now,
    input  logic [31:0] exception_like_now_pc,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_target,
    input  logic        fs_allowin,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    output logic        fs_valid,
    output logic [31:0] fs_pc,
    output logic        fs_discard
);

    localparam int CW = $clog2(QDEPTH + 1);

    logic [31:0] r_cur_pc;
    logic        r_inst_req;
    redir_t      r_pend_kind;
    logic [31:0] r_pend_target;
    logic        r_pend_disc;

    logic          w_hs;
    logic          w_pop;
    redir_t        w_kind;
    logic [31:0]   w_target;
    logic [31:0]   w_keep_pc;
    logic          w_push_disc;
    pcq_entry_t    w_push_entry;
    pcq_entry_t    w_q_head;
    logic          w_q_full;
    logic          w_q_empty;
    logic [CW-1:0] w_q_count;
    logic [CW-1:0] w_cnt_next;
    logic          w_issue;

    assign w_hs      = r_inst_req && inst_addr_ok;
    assign w_pop     = inst_data_ok && !w_q_empty;
    assign w_kind    = f_redir_sel(exception_like_now, br_taken, r_pend_kind);
    assign w_target  = (w_kind == REDIR_EXC) ? exception_like_now_pc : br_target;
    assign w_keep_pc = br_pc + 32'd4;

    // The request being accepted now (or held) inherits any discard already owed to it.
    assign w_push_disc        = r_pend_disc || f_cancels(w_kind, r_cur_pc, w_keep_pc);
    assign w_push_entry.pc      = r_cur_pc;
    assign w_push_entry.discard = w_push_disc;

    // A new request only rises if it still fits once this cycle's push/pop settle.
    assign w_cnt_next = w_q_count + CW'(w_hs) - CW'(w_pop);
    assign w_issue    = fs_allowin && (w_cnt_next < CW'(QDEPTH));

    pre_if_stage_pc_queue #(
        .QDEPTH (QDEPTH)
    ) u_pc_queue (
        .clk           (clk),
        .rst_n         (reset),
        .i_push        (w_hs),
        .i_push_entry  (w_push_entry),
        .i_pop         (w_pop),
        .i_mark_all    (w_kind == REDIR_EXC),
        .i_mark_except (w_kind == REDIR_BR),
        .i_keep_pc     (w_keep_pc),
        .o_head        (w_q_head),
        .o_full        (w_q_full),
        .o_empty       (w_q_empty),
        .o_count       (w_q_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur_pc      <= RESET_PC;
            r_inst_req    <= 1'b0;
            r_pend_kind   <= REDIR_NONE;
            r_pend_target <= '0;
            r_pend_disc   <= 1'b0;
        end else begin
            r_inst_req <= (r_inst_req && !inst_addr_ok) ? 1'b1 : w_issue;
            if (w_hs) begin
                r_pend_kind <= REDIR_NONE;
                r_pend_disc <= 1'b0;
                if (w_kind != REDIR_NONE)
                    r_cur_pc <= w_target;
                else if (r_pend_kind != REDIR_NONE)
                    r_cur_pc <= r_pend_target;
                else
                    r_cur_pc <= r_cur_pc + 32'd4;
            end else if (r_inst_req) begin
                // Address must stay stable while the bus has not accepted it.
                if (w_kind != REDIR_NONE) begin
                    r_pend_kind   <= w_kind;
                    r_pend_target <= w_target;
                    r_pend_disc   <= w_push_disc;
                end
            end else if (w_kind != REDIR_NONE) begin
                r_cur_pc <= w_target;
            end
        end
    end

    assign inst_req   = r_inst_req;
    assign inst_addr  = r_cur_pc;
    assign fs_valid   = w_pop;
    assign fs_pc      = w_q_head.pc;
    assign fs_discard = w_pop && (w_q_head.discard || f_cancels(w_kind, w_q_head.pc, w_keep_pc));

    a_no_data_when_empty: assert property (@(posedge clk) disable iff (!reset)
        !(inst_data_ok && w_q_empty));

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_hs && w_q_full && !w_pop));

endmodule

// File: tb/tb_pre_if_stage.sv
// Directed table-driven bench for pre_if_stage: one record per cycle of inputs
// and expected outputs, plus a hand-written mid-transaction reset sequence.
module tb_pre_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        exception_like_now;
    logic [31:0] exception_like_now_pc;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [31:0] br_target;
    logic        fs_allowin;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        fs_discard;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst_n;
        logic        allow;
        logic        aok;
        logic        dok;
        logic        exc;
        logic [31:0] exc_pc;
        logic        br;
        logic [31:0] brpc;
        logic [31:0] brtgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_fsv;
        logic [31:0] e_fspc;
        logic        e_disc;
    } vec_t;

    vec_t vecs[$];

    pre_if_stage #(
        .RESET_PC (32'hBFC0_0000),
        .QDEPTH   (2)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .exception_like_now    (exception_like_now),
        .exception_like_now_pc (exception_like_now_pc),
        .br_taken              (br_taken),
        .br_pc                 (br_pc),
        .br_target             (br_target),
        .fs_allowin            (fs_allowin),
        .inst_req              (inst_req),
        .inst_addr             (inst_addr),
        .inst_addr_ok          (inst_addr_ok),
        .inst_data_ok          (inst_data_ok),
        .fs_valid              (fs_valid),
        .fs_pc                 (fs_pc),
        .fs_discard            (fs_discard)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst_n, input logic allow, input logic aok, input logic dok,
                       input logic exc, input logic [31:0] exc_pc,
                       input logic br, input logic [31:0] brpc, input logic [31:0] brtgt,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic e_fsv, input logic [31:0] e_fspc, input logic e_disc);
        vec_t v;
        v.rst_n = rst_n; v.allow = allow; v.aok = aok; v.dok = dok;
        v.exc = exc; v.exc_pc = exc_pc; v.br = br; v.brpc = brpc; v.brtgt = brtgt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_fsv = e_fsv; v.e_fspc = e_fspc; v.e_disc = e_disc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        reset                 = v.rst_n;
        fs_allowin            = v.allow;
        inst_addr_ok          = v.aok;
        inst_data_ok          = v.dok;
        exception_like_now    = v.exc;
        exception_like_now_pc = v.exc_pc;
        br_taken              = v.br;
        br_pc                 = v.brpc;
        br_target             = v.brtgt;
    endtask

    initial begin
        reset = 1'b1;
        exception_like_now = 1'b0; exception_like_now_pc = '0;
        br_taken = 1'b0; br_pc = '0; br_target = '0;
        fs_allowin = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
        #1 reset = 1'b0;

        //  rst al ao do exc exc_pc        br br_pc         br_tgt        | req addr          fsv fs_pc         disc
        // sequential fetch, back-to-back handshakes
        add(0, 1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0,          0, 32'hBFC0_0000, 0, 32'h0,         0);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0,          0, 32'hBFC0_0000, 0, 32'h0,         0);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'hBFC0_0000, 0, 32'h0,         0);
        add(1, 1, 1, 1, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'hBFC0_0004, 1, 32'hBFC0_0000, 0);
        add(1, 1, 1, 1, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'hBFC0_0008, 1, 32'hBFC0_0004, 0);
        add(1, 0, 0, 1, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'hBFC0_000C, 1, 32'hBFC0_0008, 0);
        // reset again, stall addr_ok while fs_allowin toggles
        add(0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0,          0, 32'hBFC0_0000, 0, 32'h0,         0);
        add(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0,          0, 32'hBFC0_0000, 0, 32'h0,         0);
        add(1, 0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'hBFC0_0000, 0, 32'h0,         0);
        add(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'hBFC0_0000, 0, 32'h0,         0);
        add(1, 0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'hBFC0_0000, 0, 32'h0,         0);
        // fill the queue, request stays low until one entry returns
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'hBFC0_0000, 0, 32'h0,         0);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'hBFC0_0004, 0, 32'h0,         0);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0,          0, 32'hBFC0_0008, 0, 32'h0,         0);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0,          0, 32'hBFC0_0008, 0, 32'h0,         0);
        add(1, 1, 0, 1, 0, 32'h0,         0, 32'h0,         32'h0,          0, 32'hBFC0_0008, 1, 32'hBFC0_0000, 0);
        add(1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'hBFC0_0008, 0, 32'h0,         0);
        add(1, 1, 1, 1, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'hBFC0_0008, 1, 32'hBFC0_0004, 0);
        add(1, 0, 0, 1, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'hBFC0_000C, 1, 32'hBFC0_0008, 0);
        // exception during a handshake: accepted entry discarded, jump to 80001000
        add(1, 1, 1, 0, 1, 32'h8000_1000, 0, 32'h0,         32'h0,          1, 32'hBFC0_000C, 0, 32'h0,         0);
        add(1, 1, 1, 1, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'h8000_1000, 1, 32'hBFC0_000C, 1);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'h8000_1004, 0, 32'h0,         0);
        // queue holds 80001000/04, exception to BFC00380 with no request up
        add(1, 1, 0, 0, 1, 32'hBFC0_0380, 0, 32'h0,         32'h0,          0, 32'h8000_1008, 0, 32'h0,         0);
        add(1, 1, 0, 1, 0, 32'h0,         0, 32'h0,         32'h0,          0, 32'hBFC0_0380, 1, 32'h8000_1000, 1);
        add(1, 1, 0, 1, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'hBFC0_0380, 1, 32'h8000_1004, 1);
        // exception while request held: pending across a stall cycle
        add(1, 1, 0, 0, 1, 32'h8000_1000, 0, 32'h0,         32'h0,          1, 32'hBFC0_0380, 0, 32'h0,         0);
        add(1, 0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'hBFC0_0380, 0, 32'h0,         0);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'hBFC0_0380, 0, 32'h0,         0);
        add(1, 1, 1, 1, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'h8000_1000, 1, 32'hBFC0_0380, 1);
        add(1, 1, 1, 1, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'h8000_1004, 1, 32'h8000_1000, 0);
        // branch at 80001000: delay slot 80001004 kept, held 80001008 discarded
        add(1, 1, 0, 0, 0, 32'h0,         1, 32'h8000_1000, 32'h8000_2000,  1, 32'h8000_1008, 0, 32'h0,         0);
        add(1, 1, 1, 1, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'h8000_1008, 1, 32'h8000_1004, 0);
        add(1, 0, 0, 1, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'h8000_2000, 1, 32'h8000_1008, 1);
        // branch and exception in the same cycle: exception wins, all discarded
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'h8000_2000, 0, 32'h0,         0);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'h8000_2004, 0, 32'h0,         0);
        add(1, 1, 0, 1, 1, 32'h8000_0180, 1, 32'h8000_2000, 32'h8000_3000,  0, 32'h8000_2008, 1, 32'h8000_2000, 1);
        add(1, 1, 0, 1, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'h8000_0180, 1, 32'h8000_2004, 1);
        add(1, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'h8000_0180, 0, 32'h0,         0);
        add(1, 0, 0, 1, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'h8000_0184, 1, 32'h8000_0180, 0);
        // pending exception blocks a later branch; PC wraps past FFFFFFFC
        add(1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,          1, 32'h8000_0184, 0, 32'h0,         0);
        add(1, 1, 1, 0, 0, 32'h0,         1, 32'h0,         32'h1234_5678,  1, 32'h8000_0184, 0, 32'h0,         0);
        add(1, 1, 1, 1, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'hFFFF_FFFC, 1, 32'h8000_0184, 1);
        add(1, 0, 0, 1, 0, 32'h0,         0, 32'h0,         32'h0,          1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #2;
            chk($sformatf("v%0d.inst_req", i), {31'd0, inst_req}, {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d.inst_addr", i), inst_addr, vecs[i].e_addr);
            chk($sformatf("v%0d.fs_valid", i), {31'd0, fs_valid}, {31'd0, vecs[i].e_fsv});
            if (vecs[i].e_fsv) begin
                chk($sformatf("v%0d.fs_pc", i), fs_pc, vecs[i].e_fspc);
                chk($sformatf("v%0d.fs_discard", i), {31'd0, fs_discard}, {31'd0, vecs[i].e_disc});
            end
        end

        // Asynchronous reset in the middle of an accepted, unreturned request.
        @(negedge clk);
        fs_allowin = 1'b1; inst_addr_ok = 1'b1; inst_data_ok = 1'b0;
        exception_like_now = 1'b0; br_taken = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        inst_data_ok = 1'b1;
        #1;
        chk("arst.inst_req", {31'd0, inst_req}, 32'd0);
        chk("arst.inst_addr", inst_addr, 32'hBFC0_0000);
        chk("arst.fs_valid", {31'd0, fs_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1; inst_data_ok = 1'b0; inst_addr_ok = 1'b0;
        #2;
        chk("arst.rel_req", {31'd0, inst_req}, 32'd0);
        @(negedge clk);
        #2;
        chk("arst.first_req", {31'd0, inst_req}, 32'd1);
        chk("arst.first_addr", inst_addr, 32'hBFC0_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
